comp_sar_search: RTL and testbench
==================================

Name: comp_sar_search

Overview:
- Sequential successive-approximation search controller that drives the b operand of an external COMP instance and consumes its gt/lt/eq flags.
- The COMP a operand carries an unknown unsigned target. This block recovers the target value one bit per cycle by binary search.
- Sits beside COMP in the datapath library as the flag-consuming end of the comparator interface. Used for value recovery and threshold search.

Parameters:
- DATAWIDTH, 32, width of probe/result and of the attached COMP.
- CNTWIDTH, 6, width of probe counter; must satisfy 2^CNTWIDTH > DATAWIDTH+1.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- start  input  1  begin search; accepted only in IDLE.
- gt  input  1  from COMP: target > probe.
- lt  input  1  from COMP: target < probe.
- eq  input  1  from COMP: target == probe.
- probe  output  DATAWIDTH  registered candidate, drives COMP b.
- busy  output  1  high in SEARCH and CHECK.
- done  output  1  one-cycle pulse, search finished.
- found  output  1  result verified equal to target; valid from done, held until next accepted start.
- result  output  DATAWIDTH  recovered value; valid from done, held until next accepted start.
- probes  output  CNTWIDTH  number of comparisons sampled in the last search; held until next accepted start.

Behaviour:
- Clocking and reset: one clock, Clk; reset is synchronous and active-high on Rst.
- Reset values: state IDLE; probe=0, busy=0, done=0, found=0, result=0, probes=0; internal acc=0, bit index=DATAWIDTH-1.
- Reset in any state aborts the search. No done pulse is issued for the aborted search.
- Flag decode: priority eq > gt > lt. No flag asserted is treated as lt. Flags are sampled at the clock edge ending each SEARCH/CHECK cycle; COMP is combinational on the registered probe.
- IDLE:
  - busy=0.
  - On start=1: acc=0, idx=DATAWIDTH-1, probe=1<<(DATAWIDTH-1), probes=0, found=0, result=0 → SEARCH.
- SEARCH (busy=1), each cycle: probes+=1, then:
  - eq: result=probe, found=1 → DONE.
  - gt: acc |= 1<<idx.
  - lt: acc unchanged.
  - If not eq and idx>0: idx-=1, probe=(updated acc)|(1<<(idx-1)), stay.
  - If not eq and idx==0: probe=updated acc → CHECK.
- CHECK (busy=1), one cycle: probes+=1, result=acc.
  - found=1 if eq, else found=0 (target moved mid-search or inconsistent flags).
  - → DONE.
- DONE: done=1 for exactly one cycle, busy=0, probe=0 → IDLE. start is ignored in DONE.
- start while busy or in DONE is ignored. There is no queuing.
- Latency, start sampled at edge 0:
  - Early eq on probe k: done high in cycle k+1.
  - Worst case: DATAWIDTH SEARCH cycles plus 1 CHECK cycle; done in cycle DATAWIDTH+2, probes=DATAWIDTH+1.
- Arithmetic: all unsigned; acc never exceeds 2^DATAWIDTH-1; no wrap.
- Target 0 is only confirmed in CHECK, since every SEARCH probe is nonzero.

Test Plan (DATAWIDTH=8, CNTWIDTH=6, real COMP attached unless stated):
- Target 0xA5, start pulse → probe sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; eq on 8th probe; done in cycle 9; result=0xA5, found=1, probes=8.
- Target 0x80 → eq on first probe; done in cycle 2; result=0x80, found=1, probes=1.
- Target 0x00 → eight lt probes (0x80,0x40,…,0x01); CHECK probe 0x00 gives eq; done in cycle 10; result=0x00, found=1, probes=9.
- Target 0xFF → probes 0x80,0xC0,0xE0,0xF0,0xF8,0xFC,0xFE,0xFF; eq on 8th; result=0xFF, found=1, probes=8.
- COMP removed and flags tied to 0 → all treated as lt; CHECK probe 0x00 sees no eq; result=0x00, found=0, probes=9, single done pulse.
- Target 0x3C: start again while busy → no effect on the search. Rst asserted in cycle 4 → all outputs return to reset values next cycle, no done pulse; a fresh start then completes normally with result=0x3C, found=1.

Source files
------------

// File: rtl/comp_sar_search.sv
// Successive-approximation search controller. It drives COMP operand b and
// recovers the unknown operand a one bit per cycle from the gt/lt/eq flags.
module comp_sar_search #(
  parameter int DATAWIDTH = 32,
  parameter int CNTWIDTH  = 6
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic                 gt,
  input  logic                 lt,
  input  logic                 eq,
  output logic [DATAWIDTH-1:0] probe,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [DATAWIDTH-1:0] result,
  output logic [CNTWIDTH-1:0]  probes
);

  localparam int IDXW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [IDXW-1:0]      IDX_TOP = IDXW'(DATAWIDTH - 1);
  localparam logic [DATAWIDTH-1:0] MSB_ONE = DATAWIDTH'(1) << (DATAWIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_reg,  state_next;
  logic [DATAWIDTH-1:0]  probe_reg,  probe_next;
  logic [DATAWIDTH-1:0]  acc_reg,    acc_next;
  logic [IDXW-1:0]       idx_reg,    idx_next;
  logic [DATAWIDTH-1:0]  result_reg, result_next;
  logic                  found_reg,  found_next;
  logic [CNTWIDTH-1:0]   probes_reg, probes_next;

  logic [DATAWIDTH-1:0]  bit_mask;
  logic [DATAWIDTH-1:0]  acc_upd;
  logic                  is_eq;
  logic                  is_gt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg  <= IDLE;
      probe_reg  <= '0;
      acc_reg    <= '0;
      idx_reg    <= IDX_TOP;
      result_reg <= '0;
      found_reg  <= 1'b0;
      probes_reg <= '0;
    end else begin
      state_reg  <= state_next;
      probe_reg  <= probe_next;
      acc_reg    <= acc_next;
      idx_reg    <= idx_next;
      result_reg <= result_next;
      found_reg  <= found_next;
      probes_reg <= probes_next;
    end
  end

  // Flag priority eq > gt > lt; an all-zero flag set falls through as lt.
  always_comb begin
    is_eq = 1'b0;
    is_gt = 1'b0;
    casez ({eq, gt, lt})
      3'b1??:  is_eq = 1'b1;
      3'b01?:  is_gt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    probe_next  = probe_reg;
    acc_next    = acc_reg;
    idx_next    = idx_reg;
    result_next = result_reg;
    found_next  = found_reg;
    probes_next = probes_reg;
    bit_mask    = DATAWIDTH'(1) << idx_reg;
    acc_upd     = is_gt ? (acc_reg | bit_mask) : acc_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next    = '0;
          idx_next    = IDX_TOP;
          probe_next  = MSB_ONE;
          probes_next = '0;
          found_next  = 1'b0;
          result_next = '0;
          state_next  = SEARCH;
        end
      end
      SEARCH: begin
        probes_next = probes_reg + CNTWIDTH'(1);
        if (is_eq) begin
          result_next = probe_reg;
          found_next  = 1'b1;
          probe_next  = '0;
          state_next  = DONE;
        end else begin
          acc_next = acc_upd;
          if (idx_reg != '0) begin
            // Next candidate keeps the decided bits and tries the next lower one.
            idx_next   = idx_reg - IDXW'(1);
            probe_next = acc_upd | (bit_mask >> 1);
          end else begin
            probe_next = acc_upd;
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        probes_next = probes_reg + CNTWIDTH'(1);
        result_next = acc_reg;
        found_next  = is_eq;
        probe_next  = '0;
        state_next  = DONE;
      end
      DONE: begin
        probe_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign probe  = probe_reg;
  assign busy   = (state_reg == SEARCH) || (state_reg == CHECK);
  assign done   = (state_reg == DONE);
  assign found  = found_reg;
  assign result = result_reg;
  assign probes = probes_reg;

endmodule

// File: tb/tb_comp_sar_search.sv
// Scoreboard bench for comp_sar_search with a behavioural COMP model on the
// probe; a monitor checks probe traces and each done pulse against the queues.
module tb_comp_sar_search;

  localparam int DW = 8;
  localparam int CW = 6;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          start = 1'b0;
  logic          gt, lt, eq;
  logic [DW-1:0] probe;
  logic          busy, done, found;
  logic [DW-1:0] result;
  logic [CW-1:0] probes;

  logic [DW-1:0] target = '0;
  logic          flags_zero = 1'b0;

  typedef struct {
    logic [DW-1:0] result;
    logic          found;
    logic [CW-1:0] probes;
    int            lat;
    longint        t0;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] probe_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  assign gt = flags_zero ? 1'b0 : (target > probe);
  assign lt = flags_zero ? 1'b0 : (target < probe);
  assign eq = flags_zero ? 1'b0 : (target == probe);

  comp_sar_search #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .gt(gt), .lt(lt), .eq(eq),
    .probe(probe), .busy(busy), .done(done), .found(found),
    .result(result), .probes(probes)
  );

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: probe trace while busy, and full result check on each done pulse.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (busy && probe_q.size() > 0) begin
        chk("probe_trace", probe, probe_q.pop_front());
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          int   k;
          e = sb_q.pop_front();
          k = int'(($time - e.t0 - 5) / 10) + 1;
          $display("txn: result=%02h found=%0d probes=%0d done_cycle=%0d", result, found, probes, k);
          chk("result", result, e.result);
          chk("found", found, e.found);
          chk("probes", probes, e.probes);
          chk("latency", k, e.lat);
          chk("busy_in_done", busy, 0);
          chk("probe_in_done", probe, 0);
        end
      end
    end
  end

  task automatic push_trace(input logic [DW-1:0] v[]);
    foreach (v[i]) probe_q.push_back(v[i]);
  endtask

  task automatic run(input logic [DW-1:0] tgt, input bit tie0,
                     input logic [DW-1:0] er, input bit ef, input logic [CW-1:0] ep,
                     input int lat, input bit restart);
    exp_t e;
    target     = tgt;
    flags_zero = tie0;
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk);
    e.result = er; e.found = ef; e.probes = ep; e.lat = lat; e.t0 = $time;
    sb_q.push_back(e);
    @(negedge Clk);
    start = 1'b0;
    if (restart) begin
      @(negedge Clk);
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
    end
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge Clk);
    if (sb_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb_q.delete();
    end
    repeat (2) @(negedge Clk);
    chk("result_held", result, er);
    chk("trace_consumed", probe_q.size(), 0);
    probe_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_probe"}, probe, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_probes"}, probes, 0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset");
    Rst = 1'b0;
    @(negedge Clk);

    push_trace('{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5});
    run(8'hA5, 1'b0, 8'hA5, 1'b1, 6'd8, 9, 1'b0);

    push_trace('{8'h80});
    run(8'h80, 1'b0, 8'h80, 1'b1, 6'd1, 2, 1'b0);

    push_trace('{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00});
    run(8'h00, 1'b0, 8'h00, 1'b1, 6'd9, 10, 1'b0);

    push_trace('{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF});
    run(8'hFF, 1'b0, 8'hFF, 1'b1, 6'd8, 9, 1'b0);

    push_trace('{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00});
    run(8'h5A, 1'b1, 8'h00, 1'b0, 6'd9, 10, 1'b0);

    // Second start pulse while busy must not disturb the search.
    push_trace('{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h3C});
    run(8'h3C, 1'b0, 8'h3C, 1'b1, 6'd6, 7, 1'b1);

    // Abort in cycle 4: no scoreboard entry, so any done pulse is flagged.
    target     = 8'h3C;
    flags_zero = 1'b0;
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    chk("abort_busy", busy, 1);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check_reset_outputs("abort");
    Rst = 1'b0;
    repeat (12) @(negedge Clk);
    chk("abort_no_done_idle", busy, 0);

    push_trace('{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h3C});
    run(8'h3C, 1'b0, 8'h3C, 1'b1, 6'd6, 7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
